// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared widths, arbiter state encoding and helpers
package wb_port_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_HELD  = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_t;

    // Writes to r0 are architecturally discarded, so only non-zero rd is a real request.
    function automatic logic is_live(input logic [REG_ADDR_W-1:0] rd);
        return (rd != '0);
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - writeback/MDU/register-file bundle for the write-port arbiter
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic                  wb_regwrite;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0]     wb_data;
    logic                  mdu_valid;
    logic [REG_ADDR_W-1:0] mdu_rd;
    logic [DATA_W-1:0]     mdu_data;
    logic                  mdu_ready;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;
    logic                  stall_pipe;
    logic                  buf_valid;

    modport master (
        output wb_regwrite, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
        input  mdu_ready, rf_we, rf_waddr, rf_wdata, stall_pipe, buf_valid
    );

    modport slave (
        input  wb_regwrite, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
        output mdu_ready, rf_we, rf_waddr, rf_wdata, stall_pipe, buf_valid
    );

endinterface

// File: rtl/wb_port_arbiter_hold_buf.sv
// rtl/wb_port_arbiter_hold_buf.sv - one-entry MDU result holding register with starvation counter
module wb_port_arbiter_hold_buf
    import wb_port_arbiter_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_clear,
    input  logic                  i_cnt_inc,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic [DATA_W-1:0]     i_data,
    output logic                  o_valid,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic [DATA_W-1:0]     o_data,
    output logic [CNT_W-1:0]      o_cnt
);

    logic                  r_valid;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0]     r_data;
    logic [CNT_W-1:0]      r_cnt;

    // Load restarts the blocked-cycle count; clear empties the entry; increment counts a pass-over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_rd    <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_rd    <= i_rd;
            r_data  <= i_data;
            r_cnt   <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else if (i_cnt_inc) begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign o_valid = r_valid;
    assign o_rd    = r_rd;
    assign o_data  = r_data;
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter between MEM/WB and the MDU
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  bus
);

    arb_state_t            r_state;
    arb_state_t            w_next;
    logic                  r_rf_we;
    logic [REG_ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0]     r_rf_wdata;
    logic                  r_stall;

    logic                  w_we;
    logic [REG_ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0]     w_wdata;
    logic                  w_load;
    logic                  w_clear;
    logic                  w_cnt_inc;
    logic                  w_wb_live;
    logic                  w_mdu_live;
    logic                  w_starved;
    logic [CNT_W-1:0]      w_cnt_next;

    logic                  w_buf_valid;
    logic [REG_ADDR_W-1:0] w_buf_rd;
    logic [DATA_W-1:0]     w_buf_data;
    logic [CNT_W-1:0]      w_buf_cnt;

    wb_port_arbiter_hold_buf #(.CNT_W(CNT_W)) u_hold_buf (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_clear   (w_clear),
        .i_cnt_inc (w_cnt_inc),
        .i_rd      (bus.mdu_rd),
        .i_data    (bus.mdu_data),
        .o_valid   (w_buf_valid),
        .o_rd      (w_buf_rd),
        .o_data    (w_buf_data),
        .o_cnt     (w_buf_cnt)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and write-port selection; MEM/WB wins, the MDU waits in the buffer.
    always_comb begin
        w_next     = r_state;
        w_we       = 1'b0;
        w_waddr    = bus.wb_rd;
        w_wdata    = bus.wb_data;
        w_load     = 1'b0;
        w_clear    = 1'b0;
        w_cnt_inc  = 1'b0;
        w_wb_live  = bus.wb_regwrite && is_live(bus.wb_rd);
        w_mdu_live = bus.mdu_valid && !w_buf_valid && is_live(bus.mdu_rd);
        w_cnt_next = w_buf_cnt + CNT_W'(1);
        w_starved  = (w_cnt_next >= CNT_W'(STARVE_LIMIT - 1));
        case (r_state)
            ARB_IDLE: begin
                if (w_wb_live) begin
                    w_we = 1'b1;
                    if (w_mdu_live) begin
                        w_load = 1'b1;
                        w_next = ARB_HELD;
                    end
                end else if (w_mdu_live) begin
                    w_we    = 1'b1;
                    w_waddr = bus.mdu_rd;
                    w_wdata = bus.mdu_data;
                end
            end
            ARB_HELD: begin
                if (w_wb_live) begin
                    w_we = 1'b1;
                    if (bus.wb_rd == w_buf_rd) begin
                        // The newer pipeline write supersedes the older MDU result.
                        w_clear = 1'b1;
                        w_next  = ARB_IDLE;
                    end else begin
                        w_cnt_inc = 1'b1;
                        if (w_starved) begin
                            w_next = ARB_DRAIN;
                        end
                    end
                end else begin
                    w_we    = 1'b1;
                    w_waddr = w_buf_rd;
                    w_wdata = w_buf_data;
                    w_clear = 1'b1;
                    w_next  = ARB_IDLE;
                end
            end
            ARB_DRAIN: begin
                // MEM/WB is frozen this cycle and re-presents its instruction next cycle.
                w_we    = 1'b1;
                w_waddr = w_buf_rd;
                w_wdata = w_buf_data;
                w_clear = 1'b1;
                w_next  = ARB_IDLE;
            end
            default: begin
                w_next = ARB_IDLE;
            end
        endcase
    end

    // Registered write port and stall; address/data hold when no write is chosen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_stall    <= 1'b0;
        end else begin
            r_rf_we <= w_we;
            r_stall <= (w_next == ARB_DRAIN);
            if (w_we) begin
                r_rf_waddr <= w_waddr;
                r_rf_wdata <= w_wdata;
            end
        end
    end

    assign bus.mdu_ready  = ~w_buf_valid;
    assign bus.buf_valid  = w_buf_valid;
    assign bus.rf_we      = r_rf_we;
    assign bus.rf_waddr   = r_rf_waddr;
    assign bus.rf_wdata   = r_rf_wdata;
    assign bus.stall_pipe = r_stall;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_port_arbiter_if bus();

    wb_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference: an optional parked MDU result plus how many times it has been passed over.
    bit          ref_have;
    logic [4:0]  ref_rd;
    logic [31:0] ref_data;
    int          ref_passed;
    bit          ref_stall;
    bit          ref_we;
    logic [4:0]  ref_addr;
    logic [31:0] ref_wdata;
    bit          prev_stall;
    int          exp_writes;
    int          obs_writes;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ref_have   = 0;
        ref_rd     = '0;
        ref_data   = '0;
        ref_passed = 0;
        ref_stall  = 0;
        ref_we     = 0;
        ref_addr   = '0;
        ref_wdata  = '0;
        prev_stall = 0;
    endtask

    task automatic emit(input logic [4:0] a, input logic [31:0] d);
        ref_we    = 1;
        ref_addr  = a;
        ref_wdata = d;
    endtask

    // One clock of the port-sharing rules, using the inputs presented this cycle.
    task automatic model_cycle();
        bit wb_ok;
        bit mdu_ok;
        wb_ok  = bus.wb_regwrite && (bus.wb_rd != 0);
        mdu_ok = bus.mdu_valid && !ref_have && (bus.mdu_rd != 0);
        ref_we = 0;
        if (ref_stall) begin
            emit(ref_rd, ref_data);
            ref_have   = 0;
            ref_stall  = 0;
            ref_passed = 0;
        end else if (ref_have) begin
            if (!wb_ok) begin
                emit(ref_rd, ref_data);
                ref_have   = 0;
                ref_passed = 0;
            end else begin
                emit(bus.wb_rd, bus.wb_data);
                if (bus.wb_rd == ref_rd) begin
                    ref_have   = 0;
                    ref_passed = 0;
                end else begin
                    ref_passed++;
                    if (ref_passed >= LIMIT - 1) ref_stall = 1;
                end
            end
        end else begin
            if (wb_ok) begin
                emit(bus.wb_rd, bus.wb_data);
                if (mdu_ok) begin
                    ref_have   = 1;
                    ref_rd     = bus.mdu_rd;
                    ref_data   = bus.mdu_data;
                    ref_passed = 0;
                end
            end else if (mdu_ok) begin
                emit(bus.mdu_rd, bus.mdu_data);
            end
        end
    endtask

    task automatic drive(input bit wr, input logic [4:0] wrd, input logic [31:0] wd,
                         input bit mv, input logic [4:0] mrd, input logic [31:0] md);
        bus.wb_regwrite = wr;
        bus.wb_rd       = wrd;
        bus.wb_data     = wd;
        bus.mdu_valid   = mv;
        bus.mdu_rd      = mrd;
        bus.mdu_data    = md;
    endtask

    task automatic tick(input string tag);
        model_cycle();
        @(posedge clk);
        #1;
        if (ref_we) exp_writes++;
        if (bus.rf_we) obs_writes++;
        check({tag, ".rf_we"},     32'(bus.rf_we),      32'(ref_we));
        check({tag, ".rf_waddr"},  32'(bus.rf_waddr),   32'(ref_addr));
        check({tag, ".rf_wdata"},  bus.rf_wdata,        ref_wdata);
        check({tag, ".stall"},     32'(bus.stall_pipe), 32'(ref_stall));
        check({tag, ".buf_valid"}, 32'(bus.buf_valid),  32'(ref_have));
        check({tag, ".mdu_ready"}, 32'(bus.mdu_ready),  32'(!ref_have));
        check({tag, ".stall_2x"},  32'(prev_stall && bus.stall_pipe), 32'(0));
        prev_stall = bus.stall_pipe;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".rf_we"},     32'(bus.rf_we),      32'(0));
        check({tag, ".rf_waddr"},  32'(bus.rf_waddr),   32'(0));
        check({tag, ".rf_wdata"},  bus.rf_wdata,        32'(0));
        check({tag, ".stall"},     32'(bus.stall_pipe), 32'(0));
        check({tag, ".buf_valid"}, 32'(bus.buf_valid),  32'(0));
        check({tag, ".mdu_ready"}, 32'(bus.mdu_ready),  32'(1));
    endtask

    initial begin
        bit          rpt;
        bit          mhold;
        bit          r_wr;
        logic [4:0]  r_wrd;
        logic [31:0] r_wd;
        bit          r_mv;
        logic [4:0]  r_mrd;
        logic [31:0] r_md;

        exp_writes = 0;
        obs_writes = 0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #12;
        check_reset_outputs("reset");
        rst = 1'b0;
        tick("idle0");
        tick("idle1");

        // Bypass: only the MDU wants the port.
        drive(0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF);
        tick("bypass");
        check("bypass.addr", 32'(bus.rf_waddr), 32'd5);
        check("bypass.data", bus.rf_wdata, 32'hDEAD_BEEF);
        check("bypass.buf", 32'(bus.buf_valid), 32'd0);

        // Conflict then drain on the next idle writeback cycle.
        drive(1, 5'd3, 32'h11, 1, 5'd7, 32'h22);
        tick("conflict");
        check("conflict.addr", 32'(bus.rf_waddr), 32'd3);
        check("conflict.buf", 32'(bus.buf_valid), 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        tick("drain_idle");
        check("drain_idle.addr", 32'(bus.rf_waddr), 32'd7);
        check("drain_idle.data", bus.rf_wdata, 32'h22);

        // Starvation: r9 parked, pipeline writes r1..r4 back to back.
        drive(1, 5'd1, 32'h101, 1, 5'd9, 32'h99);
        tick("starve1");
        drive(1, 5'd2, 32'h102, 0, 0, 0);
        tick("starve2");
        drive(1, 5'd3, 32'h103, 0, 0, 0);
        tick("starve3");
        check("starve3.stall", 32'(bus.stall_pipe), 32'd0);
        drive(1, 5'd4, 32'h104, 0, 0, 0);
        tick("starve4");
        check("starve4.stall", 32'(bus.stall_pipe), 32'd1);
        check("starve4.addr", 32'(bus.rf_waddr), 32'd4);
        drive(1, 5'd5, 32'h105, 0, 0, 0);
        tick("stallcyc");
        check("stallcyc.stall", 32'(bus.stall_pipe), 32'd0);
        check("stallcyc.addr", 32'(bus.rf_waddr), 32'd9);
        check("stallcyc.data", bus.rf_wdata, 32'h99);
        tick("represent");
        check("represent.addr", 32'(bus.rf_waddr), 32'd5);

        // Stale discard: newer pipeline write to the parked register.
        drive(1, 5'd2, 32'h1, 1, 5'd8, 32'hAAAA);
        tick("stale_load");
        drive(1, 5'd8, 32'hBBBB, 0, 0, 0);
        tick("stale_hit");
        check("stale_hit.data", bus.rf_wdata, 32'hBBBB);
        check("stale_hit.buf", 32'(bus.buf_valid), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        tick("stale_after0");
        tick("stale_after1");
        check("stale_after.we", 32'(bus.rf_we), 32'd0);

        // r0 suppression on both sources.
        drive(1, 5'd0, 32'h77, 0, 0, 0);
        tick("r0_wb");
        drive(0, 0, 0, 1, 5'd0, 32'h66);
        tick("r0_mdu");
        drive(1, 5'd0, 32'h55, 1, 5'd0, 32'h44);
        tick("r0_both");
        check("r0.we", 32'(bus.rf_we), 32'd0);
        check("r0.buf", 32'(bus.buf_valid), 32'd0);

        // Asynchronous reset mid-cycle with a parked result.
        drive(1, 5'd3, 32'h33, 1, 5'd7, 32'h77);
        tick("pre_reset");
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        drive(0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        tick("post_reset0");
        tick("post_reset1");

        // Random traffic; a stalled writeback is re-presented, an unaccepted MDU result is held.
        rpt   = 0;
        mhold = 0;
        r_wr = 0; r_wrd = '0; r_wd = '0; r_mv = 0; r_mrd = '0; r_md = '0;
        exp_writes = 0;
        obs_writes = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!rpt) begin
                r_wr  = ($urandom_range(0, 99) < 60);
                r_wrd = 5'($urandom_range(0, 7));
                r_wd  = $urandom;
            end
            if (!mhold) begin
                r_mv  = ($urandom_range(0, 99) < 35);
                r_mrd = 5'($urandom_range(0, 7));
                r_md  = $urandom;
            end
            drive(r_wr, r_wrd, r_wd, r_mv, r_mrd, r_md);
            rpt   = ref_stall;
            mhold = r_mv && ref_have;
            tick("rand");
        end
        check("rand.write_count", 32'(obs_writes), 32'(exp_writes));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
